// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the pixel PLL lock controller.
// Holds the default timing parameters, the FSM state encoding and a small
// helper used to size the shared cycle counter.
package pll_ctrl_pkg;

    localparam int DEF_RST_PULSE_CYC    = 32;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;  // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYC       = 1024;
    localparam int DEF_MAX_RETRIES      = 7;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_ASSERT_RST = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_QUALIFY    = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_FAIL       = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// Pixel PLL lock sequencer: pulses the PLL reset, waits for lock with a
// timeout, qualifies lock for a stable period and releases the pixel domain.
// Timed-out attempts are retried until MAX_RETRIES, then the block parks in
// FAIL with the PLL held in reset until retry_req.
//
// Ports:
//   refclk          - 50 MHz reference clock (only clock)
//   rst             - synchronous active-high reset
//   locked_in       - PLL lock flag, asynchronous
//   retry_req       - single-cycle pulse, leaves FAIL (ignored elsewhere)
//   pll_rst         - reset to the pixel PLL
//   pixel_rst_req   - held high until the pixel clock is qualified
//   lock_ok         - pixel clock qualified
//   fail            - retries exhausted
//   retry_count     - timed-out attempts since the last RUN
//   lock_loss_count - lock losses seen in RUN (saturating)
//
// Build option: define PLL_LOSS_COUNT_EN to include the lock-loss counter;
// otherwise lock_loss_count is constant 0.
//
// state       | meaning
// ------------+-----------------------------------------------
// ASSERT_RST  | PLL reset asserted for RST_PULSE_CYC cycles
// WAIT_LOCK   | waiting for lock_s, bounded by LOCK_TIMEOUT_CYC
// QUALIFY     | counting STABLE_CYC consecutive locked cycles
// RUN         | lock good, pixel domain released
// FAIL        | retries exhausted, PLL held in reset
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int STABLE_CYC       = DEF_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       pixel_rst_req,
    output logic       lock_ok,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic             lock_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;

    sync_2ff u_sync_lock (
        .clk (refclk),
        .rst (rst),
        .d   (locked_in),
        .q   (lock_s)
    );

    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        case (state_q)
            ST_ASSERT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes precedence over a coincident timeout.
                if (lock_s) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_ASSERT_RST;
                    cnt_d   = '0;
                end
            end
            ST_QUALIFY: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                // Counter is idle here; hold it at 0 so it cannot wrap.
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = ST_ASSERT_RST;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
                if (retry_req) begin
                    state_d = ST_ASSERT_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_ASSERT_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= ST_ASSERT_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst       <= 1'b1;
            pixel_rst_req <= 1'b1;
            lock_ok       <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst       <= (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
            pixel_rst_req <= (state_d != ST_RUN);
            lock_ok       <= (state_d == ST_RUN);
            fail          <= (state_d == ST_FAIL);
        end
    end

    assign retry_count = retry_q;

`ifdef PLL_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // Exactly the RUN -> ASSERT_RST transition.
    assign loss_evt = (state_q == ST_RUN) && !lock_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
module tb_pll_lock_ctrl;

    localparam int RP = 4;
    localparam int TO = 100;
    localparam int SC = 8;
    localparam int MR = 3;

`ifdef PLL_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_rst, pixel_rst_req, lock_ok, fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    always #10 refclk = ~refclk;

    pll_lock_ctrl #(
        .RST_PULSE_CYC    (RP),
        .LOCK_TIMEOUT_CYC (TO),
        .STABLE_CYC       (SC),
        .MAX_RETRIES      (MR)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .locked_in       (locked_in),
        .retry_req       (retry_req),
        .pll_rst         (pll_rst),
        .pixel_rst_req   (pixel_rst_req),
        .lock_ok         (lock_ok),
        .fail            (fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus time-in-phase, lock flag delayed by a
    // two-entry queue.
    localparam int PH_PULSE = 10, PH_WAIT = 11, PH_QUAL = 12, PH_RUN = 13, PH_FAIL = 14;
    int m_phase, m_elapsed, m_retries, m_losses;
    bit m_pipe[$];
    bit m_valid = 1'b0;

    task automatic m_enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    task automatic model_edge();
        bit ls;
        ls = m_pipe.size() > 0 ? m_pipe[0] : 1'b0;
        if (rst) begin
            m_enter(PH_PULSE);
            m_retries = 0;
            m_losses  = 0;
            m_pipe    = {1'b0, 1'b0};
            m_valid   = 1'b1;
            return;
        end
        if (!m_valid) return;
        m_elapsed++;
        case (m_phase)
            PH_PULSE: if (m_elapsed == RP) m_enter(PH_WAIT);
            PH_WAIT: begin
                if (ls) m_enter(PH_QUAL);
                else if (m_elapsed == TO) begin
                    m_retries++;
                    m_enter(m_retries == MR ? PH_FAIL : PH_PULSE);
                end
            end
            PH_QUAL: begin
                if (!ls) m_enter(PH_WAIT);
                else if (m_elapsed == SC) begin
                    m_enter(PH_RUN);
                    m_retries = 0;
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    m_enter(PH_PULSE);
                    if (LOSS_EN && m_losses < 255) m_losses++;
                end
            end
            default: begin
                if (retry_req) begin
                    m_enter(PH_PULSE);
                    m_retries = 0;
                end
            end
        endcase
        void'(m_pipe.pop_front());
        m_pipe.push_back(locked_in);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        if (m_valid) begin
            chk("m_pll_rst", pll_rst, int'(m_phase == PH_PULSE || m_phase == PH_FAIL));
            chk("m_pixel_rst_req", pixel_rst_req, int'(m_phase != PH_RUN));
            chk("m_lock_ok", lock_ok, int'(m_phase == PH_RUN));
            chk("m_fail", fail, int'(m_phase == PH_FAIL));
            chk("m_retry_count", retry_count, m_retries);
            chk("m_lock_loss_count", lock_loss_count, m_losses);
        end
    endtask

    task automatic wait_lock_ok(input bit want, input int budget, output int took);
        took = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (lock_ok == want) begin
                took = i;
                break;
            end
        end
    endtask

    typedef struct {
        bit rst;
        bit lk;
        bit rr;
        bit e_pll;
        bit e_ok;
        bit e_pix;
        bit e_fail;
        int e_retry;
    } vec_t;

    vec_t tbl[35];

    initial begin
        int t, rises, prev, first, seg, val, drops;

        // Clean lock: cycle c is the c-th edge after the reset edge (c=0).
        // A retry_req during WAIT_LOCK (c=10) must be ignored.
        for (int c = 0; c < 35; c++) begin
            tbl[c].rst     = (c == 0);
            tbl[c].lk      = (c >= 20);
            tbl[c].rr      = (c == 10);
            tbl[c].e_pll   = (c < RP);
            tbl[c].e_ok    = (c >= 20 + 2 + SC);
            tbl[c].e_pix   = !(c >= 20 + 2 + SC);
            tbl[c].e_fail  = 1'b0;
            tbl[c].e_retry = 0;
        end

        rst = 1'b1;
        tick();
        for (int c = 0; c < 35; c++) begin
            rst       = tbl[c].rst;
            locked_in = tbl[c].lk;
            retry_req = tbl[c].rr;
            tick();
            chk($sformatf("tbl_pll_rst[%0d]", c), pll_rst, tbl[c].e_pll);
            chk($sformatf("tbl_lock_ok[%0d]", c), lock_ok, tbl[c].e_ok);
            chk($sformatf("tbl_pixel_rst_req[%0d]", c), pixel_rst_req, tbl[c].e_pix);
            chk($sformatf("tbl_fail[%0d]", c), fail, tbl[c].e_fail);
            chk($sformatf("tbl_retry_count[%0d]", c), retry_count, tbl[c].e_retry);
        end
        retry_req = 1'b0;

        // Lock never arrives.
        rst = 1'b1; locked_in = 1'b0;
        tick();
        rst = 1'b0;
        rises = 0;
        prev  = pll_rst;
        for (int c = 1; c <= 320; c++) begin
            tick();
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
            if (c == 103) chk("nolock_pll_rst_103", pll_rst, 0);
            if (c == 104) chk("nolock_pll_rst_104", pll_rst, 1);
            if (c == 104) chk("nolock_retry_1", retry_count, 1);
            if (c == 108) chk("nolock_pll_rst_108", pll_rst, 0);
            if (c == 208) chk("nolock_retry_2", retry_count, 2);
            if (c == 311) chk("nolock_fail_311", fail, 0);
            if (c == 312) chk("nolock_retry_3", retry_count, 3);
            if (c == 312) chk("nolock_fail_312", fail, 1);
        end
        chk("nolock_pulse_rises", rises, 3);
        chk("nolock_pll_rst_held", pll_rst, 1);
        chk("nolock_fail_held", fail, 1);

        // Recovery from FAIL.
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        locked_in = 1'b1;
        chk("recover_fail", fail, 0);
        chk("recover_retry", retry_count, 0);
        wait_lock_ok(1'b1, 40, t);
        chk("recover_lock_time", t, 13);

        // Glitch during QUALIFY.
        rst = 1'b1; locked_in = 1'b0;
        tick();
        rst = 1'b0;
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            locked_in = (c >= 10 && c <= 14) || (c >= 16);
            tick();
            if (lock_ok && first < 0) first = c;
        end
        chk("glitch_lock_time", first, 16 + 2 + SC);

        // Loss in RUN, repeated.
        drops = 0;
        for (int i = 1; i <= 300; i++) begin
            locked_in = 1'b0;
            tick();
            locked_in = 1'b1;
            wait_lock_ok(1'b0, 5, t);
            if (t > 0) drops++;
            wait_lock_ok(1'b1, 30, t);
            chk("loss_relock", int'(t > 0), 1);
            if (i == 255 || i == 256)
                chk($sformatf("loss_count_%0d", i), lock_loss_count, LOSS_EN ? 255 : 0);
        end
        chk("loss_drops", drops, 300);
        chk("loss_count_final", lock_loss_count, LOSS_EN ? 255 : 0);

        // Reset mid-RUN.
        chk("midrun_in_run", lock_ok, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_pll_rst", pll_rst, 1);
        chk("midrun_pixel_rst_req", pixel_rst_req, 1);
        chk("midrun_lock_ok", lock_ok, 0);
        chk("midrun_fail", fail, 0);
        chk("midrun_retry", retry_count, 0);
        chk("midrun_loss", lock_loss_count, 0);

        // Randomized traffic checked against the model.
        seg = 0;
        val = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    seg = $urandom_range(100, 350);
                    val = 0;
                end else begin
                    seg = $urandom_range(1, 20);
                    val = ($urandom_range(0, 3) != 0);
                end
            end
            seg--;
            locked_in = val[0];
            retry_req = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 32: PLL reset pulse length in refclk cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYC, default 50000: maximum refclk cycles spent waiting for lock, 1 ms at 50 MHz.
REQ-003 SHALL have parameter STABLE_CYC, default 1024: consecutive locked cycles required before lock is declared good.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: number of timed-out lock attempts before the block declares failure.
REQ-005 SHALL have port refclk, input, 1 bit: 50 MHz reference clock, the only clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port locked_in, input, 1 bit: PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port retry_req, input, 1 bit: single-cycle pulse that leaves FAIL.
REQ-009 SHALL have port pll_rst, output, 1 bit: reset to the pixel PLL.
REQ-010 SHALL have port pixel_rst_req, output, 1 bit: high until the pixel clock is qualified.
REQ-011 SHALL have port lock_ok, output, 1 bit: pixel clock qualified.
REQ-012 SHALL have port fail, output, 1 bit: retries exhausted.
REQ-013 SHALL have port retry_count, output, 4 bits: timed-out attempts since the last RUN.
REQ-014 SHALL have port lock_loss_count, output, 8 bits: count of lock losses seen while in RUN.

Function
REQ-015 SHALL pass locked_in through a 2-flop synchronizer to form lock_s, giving 2 refclk cycles of latency.
REQ-016 SHALL implement the FSM states ASSERT_RST, WAIT_LOCK, QUALIFY, RUN and FAIL, with one shared cycle counter that is cleared on every state entry.
REQ-017 In ASSERT_RST, SHALL drive pll_rst=1 for exactly RST_PULSE_CYC cycles and then enter WAIT_LOCK.
REQ-018 In WAIT_LOCK with lock_s=1, SHALL enter QUALIFY.
REQ-019 In WAIT_LOCK with lock_s=0 when the counter reaches LOCK_TIMEOUT_CYC-1, SHALL increment retry_count and, in the same cycle:
  - enter FAIL if the new retry_count equals MAX_RETRIES;
  - otherwise enter ASSERT_RST.
REQ-020 If lock_s=1 and the timeout occur in the same cycle, the lock SHALL win and the FSM SHALL enter QUALIFY.
REQ-021 In QUALIFY, lock_s=0 SHALL send the FSM back to WAIT_LOCK with the timer restarted.
REQ-022 In QUALIFY, after STABLE_CYC consecutive cycles of lock_s=1 the FSM SHALL enter RUN and clear retry_count.
REQ-023 In RUN, SHALL drive lock_ok=1 and pixel_rst_req=0; in every other state SHALL drive lock_ok=0 and pixel_rst_req=1.
REQ-024 In RUN, lock_s=0 SHALL send the FSM to ASSERT_RST on the next cycle and drop lock_ok in that same cycle.
REQ-025 In FAIL, SHALL hold pll_rst=1 and fail=1; retry_req=1 SHALL clear retry_count and fail and enter ASSERT_RST.
REQ-026 retry_req in any state other than FAIL SHALL be ignored.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL force, on the next refclk edge:
  - state ASSERT_RST with the counter at 0;
  - pll_rst=1, pixel_rst_req=1, lock_ok=0, fail=0;
  - retry_count=0, lock_loss_count=0;
  - both synchronizer flops to 0.
REQ-029 rst asserted mid-operation, including in RUN or FAIL, SHALL take priority over every transition.

Configuration
REQ-030 With macro PLL_LOSS_COUNT_EN defined, SHALL increment lock_loss_count on each RUN-to-ASSERT_RST transition, saturating at 255.
REQ-031 Without PLL_LOSS_COUNT_EN, lock_loss_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-032 SHALL place the FSM state enum and the default parameter constants in shared package pll_ctrl_pkg.
REQ-033 SHALL implement the synchronizer as sub-module sync_2ff, instantiated once.

Verification
REQ-034 Bench parameters SHALL be RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, STABLE_CYC=8, MAX_RETRIES=3.
REQ-035 Bench SHALL cover each scenario below (stimulus -> required response):
  - Clean lock: release rst, then locked_in=1 at cycle 20 -> pll_rst is high cycles 1-4 only; lock_ok rises at 20+2+8 (±1 for FSM entry), and pixel_rst_req falls in the same cycle.
  - Lock never arrives: locked_in held 0 -> three 4-cycle pll_rst pulses, each roughly 104 cycles apart; retry_count steps 1, 2, 3; fail=1 after the third timeout and pll_rst stays high.
  - Recovery from FAIL: one-cycle pulse on retry_req, then locked_in=1 -> fail=0 and retry_count=0 next cycle, and lock_ok=1 after qualification.
  - Glitch during QUALIFY: locked_in high 5 cycles, low 1, then high -> lock_ok is reached only 8 stable cycles after the final rise.
  - Loss in RUN with PLL_LOSS_COUNT_EN defined: drop locked_in 300 times -> lock_ok drops each time; lock_loss_count saturates at 255; with the macro undefined, lock_loss_count stays 0.
  - Reset mid-RUN: rst=1 for one cycle -> all outputs return to their reset values on the next edge.
